// File: rtl/cve2_hpm_counters.sv
// cve2_hpm_counters: machine cycle/instret/hpm counters, mhpmevent, mcountinhibit.
// Ports: clk_i/rst_ni; CSR re/we/addr/wdata -> registered rdata/rvalid/illegal;
// instr_ret_i and event_i count sources; ovf_o one-cycle wrap pulse per counter.
module cve2_hpm_counters #(
  parameter int unsigned NumHpm    = 2,
  parameter int unsigned HpmWidth  = 40,
  parameter int unsigned NumEvents = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 csr_re_i,
  input  logic                 csr_we_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_rvalid_o,
  output logic                 csr_illegal_o,
  input  logic                 instr_ret_i,
  input  logic [NumEvents-1:0] event_i,
  output logic [NumHpm+1:0]    ovf_o
);

  localparam int unsigned NH = (NumHpm > 0) ? NumHpm : 1;

  function automatic logic [31:0] inh_mask();
    logic [31:0] m;
    m = 32'h5;
    for (int k = 0; k < int'(NumHpm); k++) m[k+3] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] InhMask = inh_mask();

  logic [63:0]          mcycle_q, mcycle_d;
  logic [63:0]          minstret_q, minstret_d;
  logic [HpmWidth-1:0]  hpm_q [NH];
  logic [HpmWidth-1:0]  hpm_d [NH];
  logic [NumEvents-1:0] evt_q [NH];
  logic [NumEvents-1:0] evt_d [NH];
  logic [31:0]          inh_q, inh_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 illegal_q, illegal_d;
  logic [NumHpm+1:0]    ovf_q, ovf_d;

  logic                 mc_ovf, mi_ovf;
  logic                 hpm_ovf [NH];

  logic [4:0]  idx;
  logic        is_inh, is_evt, is_lo, is_hi, legal;
  logic        wr, wr_lo, wr_hi, wr_evt;
  logic [63:0] cnt_tab [32];
  logic [31:0] evt_tab [32];
  logic [63:0] cnt_sel;
  logic [31:0] rd_val;

  assign idx    = csr_addr_i[4:0];
  assign is_inh = csr_addr_i == 12'h320;
  assign is_evt = (csr_addr_i[11:5] == 7'h19) && (idx >= 5'd3);
  // Index 1 (time) is not ours in either counter window.
  assign is_lo  = (csr_addr_i[11:5] == 7'h58) && (idx != 5'd1);
  assign is_hi  = (csr_addr_i[11:5] == 7'h5C) && (idx != 5'd1);
  assign legal  = is_inh | is_evt | is_lo | is_hi;

  assign wr     = csr_we_i & legal;
  assign wr_lo  = wr & is_lo;
  assign wr_hi  = wr & is_hi;
  assign wr_evt = wr & is_evt;

  // Flat view indexed by CSR low bits; unimplemented slots read 0.
  genvar i;
  for (i = 0; i < 32; i++) begin : g_tab
    if (i == 0) begin : g_mc
      assign cnt_tab[i] = mcycle_q;
      assign evt_tab[i] = '0;
    end else if (i == 2) begin : g_mi
      assign cnt_tab[i] = minstret_q;
      assign evt_tab[i] = '0;
    end else if (i >= 3 && i < 3 + NumHpm) begin : g_hp
      assign cnt_tab[i] = 64'(hpm_q[i-3]);
      assign evt_tab[i] = 32'(evt_q[i-3]);
    end else begin : g_none
      assign cnt_tab[i] = '0;
      assign evt_tab[i] = '0;
    end
  end

  assign cnt_sel = cnt_tab[idx];

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      is_inh:  rd_val = inh_q;
      is_evt:  rd_val = evt_tab[idx];
      is_lo:   rd_val = cnt_sel[31:0];
      is_hi:   rd_val = cnt_sel[63:32];
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    rvalid_d  = csr_re_i;
    rdata_d   = csr_re_i ? rd_val : 32'd0;
    illegal_d = (csr_re_i | csr_we_i) & ~legal;
    inh_d     = (wr & is_inh) ? (csr_wdata_i & InhMask) : inh_q;
  end

  // A write to either half suppresses that cycle's increment.
  always_comb begin
    mcycle_d = mcycle_q;
    mc_ovf   = 1'b0;
    if (wr_lo && idx == 5'd0) begin
      mcycle_d[31:0] = csr_wdata_i;
    end else if (wr_hi && idx == 5'd0) begin
      mcycle_d[63:32] = csr_wdata_i;
    end else if (!inh_q[0]) begin
      mcycle_d = mcycle_q + 64'd1;
      mc_ovf   = &mcycle_q;
    end
  end

  always_comb begin
    minstret_d = minstret_q;
    mi_ovf     = 1'b0;
    if (wr_lo && idx == 5'd2) begin
      minstret_d[31:0] = csr_wdata_i;
    end else if (wr_hi && idx == 5'd2) begin
      minstret_d[63:32] = csr_wdata_i;
    end else if (!inh_q[2] && instr_ret_i) begin
      minstret_d = minstret_q + 64'd1;
      mi_ovf     = &minstret_q;
    end
  end

  assign ovf_d[0] = mc_ovf;
  assign ovf_d[1] = mi_ovf;

  genvar k;
  for (k = 0; k < NumHpm; k++) begin : g_hpm
    logic [63:0] tmp;
    logic        hit_lo, hit_hi, inc;
    always_comb begin
      hit_lo = wr_lo && (idx == 5'(k + 3));
      // High half only exists above 32 bits.
      hit_hi = wr_hi && (idx == 5'(k + 3)) && (HpmWidth > 32);
      inc    = !inh_q[k+3] && (|(event_i & evt_q[k]));
      tmp    = 64'(hpm_q[k]);
      if (hit_lo) tmp[31:0] = csr_wdata_i;
      if (hit_hi) tmp[63:32] = csr_wdata_i;
      hpm_ovf[k] = 1'b0;
      if (hit_lo || hit_hi) begin
        hpm_d[k] = tmp[HpmWidth-1:0];
      end else if (inc) begin
        hpm_d[k]   = hpm_q[k] + HpmWidth'(1);
        hpm_ovf[k] = &hpm_q[k];
      end else begin
        hpm_d[k] = hpm_q[k];
      end
      evt_d[k] = (wr_evt && (idx == 5'(k + 3))) ?
                 csr_wdata_i[NumEvents-1:0] : evt_q[k];
    end
    assign ovf_d[k+2] = hpm_ovf[k];
  end

  if (NumHpm == 0) begin : g_nohpm
    assign hpm_d[0]   = '0;
    assign evt_d[0]   = '0;
    assign hpm_ovf[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      for (int n = 0; n < int'(NH); n++) begin
        hpm_q[n] <= '0;
        evt_q[n] <= '0;
      end
      inh_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      illegal_q  <= 1'b0;
      ovf_q      <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      for (int n = 0; n < int'(NH); n++) begin
        hpm_q[n] <= hpm_d[n];
        evt_q[n] <= evt_d[n];
      end
      inh_q      <= inh_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      illegal_q  <= illegal_d;
      ovf_q      <= ovf_d;
    end
  end

  assign csr_rdata_o   = rdata_q;
  assign csr_rvalid_o  = rvalid_q;
  assign csr_illegal_o = illegal_q;
  assign ovf_o         = ovf_q;

endmodule
